// File: rtl/byte_serial_sub.sv
// Byte-serial multi-precision subtractor: one byte per clock, LSB first, with a registered borrow.
// Optional add mode (op_add port) is enabled by defining BYTE_SUB_ADD_MODE_EN.
module byte_serial_sub #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  borrow_in,
`ifdef BYTE_SUB_ADD_MODE_EN
  input  logic                  op_add,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   diff,
  output logic                  borrow_out,
  output logic                  overflow,
  output logic                  zero
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // RUN   | processing byte idx_q, one byte per cycle
  // DONE  | result held, out_valid=1 until out_ready

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q, diff_q, diff_nxt;
  logic [IW-1:0] idx_q;
  logic          br_q, bo_q, ov_q, z_q;
  logic          add_q;
  logic [7:0]    a_byte, b_byte;
  logic [8:0]    sum;
  logic          last, ov_nxt;

`ifndef BYTE_SUB_ADD_MODE_EN
  assign add_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_byte = a_q[{idx_q, 3'b000} +: 8];
    b_byte = b_q[{idx_q, 3'b000} +: 8];
    if (add_q) sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, br_q};
    else       sum = {1'b0, a_byte} - {1'b0, b_byte} - {8'b0, br_q};
    diff_nxt = diff_q;
    diff_nxt[{idx_q, 3'b000} +: 8] = sum[7:0];
    last = (idx_q == LAST);
    // on the last byte, sum[7] is the result MSB
    if (add_q) ov_nxt = (a_q[W-1] == b_q[W-1]) && (sum[7] != a_q[W-1]);
    else       ov_nxt = (a_q[W-1] != b_q[W-1]) && (sum[7] != a_q[W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      idx_q  <= '0;
      br_q   <= 1'b0;
      bo_q   <= 1'b0;
      ov_q   <= 1'b0;
      z_q    <= 1'b0;
`ifdef BYTE_SUB_ADD_MODE_EN
      add_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= borrow_in;
            idx_q <= '0;
`ifdef BYTE_SUB_ADD_MODE_EN
            add_q <= op_add;
`endif
          end
        end
        RUN: begin
          diff_q <= diff_nxt;
          br_q   <= sum[8];
          idx_q  <= idx_q + 1'b1;
          if (last) begin
            bo_q <= sum[8];
            ov_q <= ov_nxt;
            z_q  <= ~|diff_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;
  assign zero       = z_q;

endmodule

// File: tb/tb_byte_serial_sub.sv
// Directed bench for byte_serial_sub: NBYTES=4 and NBYTES=1 instances, plus add mode
// when BYTE_SUB_ADD_MODE_EN is defined.
module tb_byte_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv4, ir4, ov4, or4, bin4, bo4, ovf4, z4;
  logic [31:0] a4, b4, d4;
  logic        iv1, ir1, ov1, or1, bin1, bo1, ovf1, z1;
  logic [7:0]  a1, b1, d1;
`ifdef BYTE_SUB_ADD_MODE_EN
  logic        add4, add1;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  byte_serial_sub #(.NBYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .borrow_in(bin4),
`ifdef BYTE_SUB_ADD_MODE_EN
    .op_add(add4),
`endif
    .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow_out(bo4),
    .overflow(ovf4), .zero(z4)
  );

  byte_serial_sub #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .borrow_in(bin1),
`ifdef BYTE_SUB_ADD_MODE_EN
    .op_add(add1),
`endif
    .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow_out(bo1),
    .overflow(ovf1), .zero(z1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept4(input logic [31:0] av, input logic [31:0] bv, input logic bi);
    a4 = av; b4 = bv; bin4 = bi; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic wait4(output int cnt);
    cnt = 0;
    while (ov4 !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic consume4();
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    check("post_hs_out_valid", {31'b0, ov4}, 32'd0);
    check("post_hs_in_ready",  {31'b0, ir4}, 32'd1);
  endtask

  task automatic check_reset4();
    check("rst_in_ready",   {31'b0, ir4},  32'd1);
    check("rst_out_valid",  {31'b0, ov4},  32'd0);
    check("rst_diff",       d4,            32'd0);
    check("rst_borrow_out", {31'b0, bo4},  32'd0);
    check("rst_overflow",   {31'b0, ovf4}, 32'd0);
    check("rst_zero",       {31'b0, z4},   32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
`ifdef BYTE_SUB_ADD_MODE_EN
    add4 = 1'b0; add1 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset4();
    check("rst1_in_ready", {31'b0, ir1}, 32'd1);
    check("rst1_diff",     {24'b0, d1},  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0 - 1
    accept4(32'h0000_0000, 32'h0000_0001, 1'b0);
    wait4(n);
    check("op1_latency",  n,             32'd4);
    check("op1_diff",     d4,            32'hFFFF_FFFF);
    check("op1_borrow",   {31'b0, bo4},  32'd1);
    check("op1_overflow", {31'b0, ovf4}, 32'd0);
    check("op1_zero",     {31'b0, z4},   32'd0);
    consume4();

    // signed overflow
    accept4(32'h8000_0000, 32'h0000_0001, 1'b0);
    wait4(n);
    check("op2_latency",  n,             32'd4);
    check("op2_diff",     d4,            32'h7FFF_FFFF);
    check("op2_borrow",   {31'b0, bo4},  32'd0);
    check("op2_overflow", {31'b0, ovf4}, 32'd1);
    consume4();

    // borrow_in cancels the difference
    accept4(32'h1234_5678, 32'h1234_5677, 1'b1);
    wait4(n);
    check("op3_diff",     d4,            32'd0);
    check("op3_zero",     {31'b0, z4},   32'd1);
    check("op3_borrow",   {31'b0, bo4},  32'd0);
    check("op3_overflow", {31'b0, ovf4}, 32'd0);

    // backpressure with input noise
    for (int i = 0; i < 10; i++) begin
      a4 = $urandom; b4 = $urandom; iv4 = i[0];
      @(posedge clk); #1;
      check("bp_diff",      d4,           32'd0);
      check("bp_zero",      {31'b0, z4},  32'd1);
      check("bp_in_ready",  {31'b0, ir4}, 32'd0);
      check("bp_out_valid", {31'b0, ov4}, 32'd1);
    end
    iv4 = 1'b0;
    consume4();

    // reset after two bytes processed
    accept4(32'hAAAA_AAAA, 32'h0000_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset4();
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_result", {31'b0, ov4}, 32'd0);
    accept4(32'd5, 32'd3, 1'b0);
    wait4(n);
    check("post_rst_latency", n,            32'd4);
    check("post_rst_diff",    d4,           32'd2);
    check("post_rst_borrow",  {31'b0, bo4}, 32'd0);
    check("post_rst_zero",    {31'b0, z4},  32'd0);
    consume4();

    // single-byte instance
    a1 = 8'h00; b1 = 8'hFF; bin1 = 1'b1; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    n = 0;
    while (ov1 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("n1_latency",  n,             32'd1);
    check("n1_diff",     {24'b0, d1},   32'd0);
    check("n1_borrow",   {31'b0, bo1},  32'd1);
    check("n1_zero",     {31'b0, z1},   32'd1);
    check("n1_overflow", {31'b0, ovf1}, 32'd0);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    check("n1_post_hs_in_ready", {31'b0, ir1}, 32'd1);

`ifdef BYTE_SUB_ADD_MODE_EN
    add4 = 1'b1;
    accept4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    add4 = 1'b0;
    wait4(n);
    check("add1_diff",     d4,            32'd0);
    check("add1_carry",    {31'b0, bo4},  32'd1);
    check("add1_zero",     {31'b0, z4},   32'd1);
    check("add1_overflow", {31'b0, ovf4}, 32'd0);
    consume4();

    add4 = 1'b1;
    accept4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    add4 = 1'b0;
    wait4(n);
    check("add2_diff",     d4,            32'h8000_0000);
    check("add2_carry",    {31'b0, bo4},  32'd0);
    check("add2_overflow", {31'b0, ovf4}, 32'd1);
    consume4();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_serial_sub.md
# byte_serial_sub

Byte-serial multi-precision subtractor for the CLA datapath. It subtracts two `8*NBYTES`-bit operands one byte per clock, least-significant byte first. A registered borrow carries between bytes, so it is the borrow-propagating counterpart of the carry lookahead chain. It serves narrow-area control paths where a full-width lookahead subtractor is not justified, and uses a valid/ready handshake on both the operand side and the result side.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 1..16.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: operands are presented.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input `8*NBYTES`: minuend, unsigned/two's complement.
- `b` input `8*NBYTES`: subtrahend.
- `borrow_in` input 1: initial borrow.
- `out_valid` output 1: result is valid; high only in DONE.
- `out_ready` input 1: consumer accepts the result.
- `diff` output `8*NBYTES`: `a - b - borrow_in`, modulo 2^(8*NBYTES).
- `borrow_out` output 1: final borrow; 1 iff `a < b + borrow_in` (unsigned).
- `overflow` output 1: signed overflow, i.e. `a`[MSB] != `b`[MSB] and `diff`[MSB] != `a`[MSB].
- `zero` output 1: `diff == 0`.
- `op_add` input 1: present only with `BYTE_SUB_ADD_MODE_EN`; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid && in_ready`: latch `a`, `b` and `borrow_in` (plus `op_add` if present).
  - Clear the byte index to 0 and enter RUN.
- **RUN**
  - Each cycle computes `{br, d} = a_byte[idx] - b_byte[idx] - br` as a 9-bit operation.
  - Writes `d` to `diff` byte `idx`, updates the borrow register and increments `idx`.
  - When `idx == NBYTES-1` is processed, enter DONE.
  - Input handshake signals are ignored.
- **DONE**
  - `out_valid=1`.
  - `diff`, `borrow_out`, `overflow` and `zero` are stable and held while `out_ready=0`.
  - On `out_valid && out_ready`: enter IDLE.
- Operands are sampled only on the accepting edge. Changes to `a`/`b` afterwards have no effect.
- Flags are registered on the edge that enters DONE.
  - `zero` is a reduction over the completed `diff`.
  - `overflow` uses the latched MSBs.
- **Width rules**
  - The byte index is `$clog2(NBYTES)` bits, with a minimum of 1.
  - Internal byte arithmetic is 9 bits; no other widening.
- **Reset**, synchronous, at any state including mid-RUN:
  - State goes to IDLE; any pending operation is discarded and not reported.
  - Output values after reset: `in_ready=1`, `out_valid=0`, `diff=0`, `borrow_out=0`, `overflow=0`, `zero=0`.
- **`NBYTES=1`**: RUN lasts exactly one cycle.

## Timing
- Latency: `out_valid` rises after exactly `NBYTES+1` rising edges counted from and including the accepting edge. With `NBYTES=4`: accept at edge 0, bytes processed at edges 1..4, `out_valid` high after edge 4.
- Wait, in cycle terms: the accepting edge only latches; bytes are processed on edges 1..NBYTES; `out_valid` is high from the cycle after edge `NBYTES`.
- Result handshake: when it completes at edge k, `in_ready` is high from edge k onward. The earliest next accept is edge k+1, so there is no same-edge result-and-accept overlap.
- Throughput: one operation per `NBYTES+2` cycles with `out_ready` tied high.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- Macro `BYTE_SUB_ADD_MODE_EN`.
- **Defined**
  - Port `op_add` exists and is latched at accept.
  - When `op_add=1`, RUN computes `{c, d} = a_byte + b_byte + c`, with `borrow_in` acting as carry-in.
  - `borrow_out` reports the final carry.
  - `overflow` becomes: `a`[MSB] == `b`[MSB] and `diff`[MSB] != `a`[MSB].
  - When `op_add=0`, behaviour is identical to the undefined case.
- **Undefined**: no `op_add` port; the block only subtracts.

## Test plan
- `NBYTES=4`; `a=0x00000000`, `b=0x00000001`, `borrow_in=0` -> `diff=0xFFFFFFFF`, `borrow_out=1`, `overflow=0`, `zero=0`; `out_valid` rises exactly 4 edges after accept.
- `a=0x80000000`, `b=0x00000001`, `borrow_in=0` -> `diff=0x7FFFFFFF`, `borrow_out=0`, `overflow=1`. Then `a=0x12345678`, `b=0x12345677`, `borrow_in=1` -> `diff=0`, `zero=1`, `borrow_out=0`.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE, toggling `a`/`b`/`in_valid` -> outputs unchanged and `in_ready=0` throughout. Release -> one handshake, then `in_ready=1` on the next cycle.
- Reset mid-RUN: drop `rst_n` for one edge after byte 2 -> all outputs at reset values. A new operation `a=5`, `b=3` -> `diff=2`, with no residue from the aborted operation.
- `NBYTES=1`: `a=0x00`, `b=0xFF`, `borrow_in=1` -> `diff=0x00`, `borrow_out=1`, `zero=1`; `out_valid` appears after 2 edges counting the accepting edge.
- With `BYTE_SUB_ADD_MODE_EN`: `op_add=1`, `a=0xFFFFFFFF`, `b=0x00000001`, `borrow_in=0` -> `diff=0`, `borrow_out=1`, `zero=1`, `overflow=0`. Then `a=0x7FFFFFFF`, `b=1` -> `diff=0x80000000`, `overflow=1`.
